axi_led_pwm_ctrl: RTL
=====================

// Module: axi_led_pwm_ctrl
// PURPOSE
//  AXI4-Lite slave driving NUM_LEDS board LEDs with per-LED 8-bit PWM brightness and masked blinking.
//  Generalised successor of the fixed 4-register LED slave.
//  Sits in the block design behind the AXI interconnect/master VIP; led_o goes to top-level pins.
// PARAMETERS
//  NUM_LEDS            8   LED count, 1..32
//  C_S_AXI_DATA_WIDTH  32  fixed; any other value is an elaboration error
//  C_S_AXI_ADDR_WIDTH  6   byte address width; 2**AW >= 16+4*NUM_LEDS, else elaboration error
//  PWM_DIV             1   ACLK cycles per PWM counter step, >=1
// PORTS
//  ACLK                     in   1        sole clock
//  ARESETN                  in   1        async assert, active-low; deassert sync to ACLK externally
//  S_AXI_AWADDR/AWPROT      in   AW/3     write address; AWPROT ignored
//  S_AXI_AWVALID/AWREADY    in/out 1      write address handshake
//  S_AXI_WDATA/WSTRB        in   32/4     write data, byte strobes honoured
//  S_AXI_WVALID/WREADY      in/out 1      write data handshake
//  S_AXI_BRESP/BVALID       out  2/1      write response
//  S_AXI_BREADY             in   1
//  S_AXI_ARADDR/ARPROT      in   AW/3     read address; ARPROT ignored
//  S_AXI_ARVALID/ARREADY    in/out 1      read address handshake
//  S_AXI_RDATA/RRESP        out  32/2     read data/response
//  S_AXI_RVALID/RREADY      out/in 1      read data handshake
//  led_o                    out  NUM_LEDS LED drive, active-high
// BEHAVIOUR
//  Map (word index = ADDR[AW-1:2]):
//   0x00 CTRL    [0] global enable, [1] blink enable
//   0x04 LED_ON  [N-1:0] on mask
//   0x08 BLINK   [N-1:0] blink mask
//   0x0C PERIOD  [31:0] half-period, in ACLK cycles
//   0x10+4i DUTY_i [7:0], i < NUM_LEDS
//  - Register bits outside the listed fields read 0.
//  Reset: all registers 0; AWREADY/WREADY/ARREADY/BVALID/RVALID 0; BRESP/RRESP/RDATA 0; led_o 0.
//  Write channel:
//   - One outstanding write.
//   - AWREADY and WREADY pulse together for 1 cycle when AWVALID && WVALID && !BVALID.
//   - Register updates on that edge.
//   - BVALID is asserted on the next cycle and held until BREADY.
//  Read channel:
//   - ARREADY pulses 1 cycle when ARVALID && !RVALID.
//   - RDATA/RRESP/RVALID appear on the next cycle, held stable until RREADY.
//  Responses:
//   - Unmapped address (word >= 4+NUM_LEDS): write ignored with BRESP=SLVERR(2'b10); read returns RDATA=0, RRESP=SLVERR.
//   - Otherwise OKAY.
//  Simultaneous read and write: both channels are independent; a read in the same cycle as the write
//   returns the pre-write value.
//  PWM:
//   - 8-bit pwm_cnt advances every PWM_DIV cycles and wraps 255->0.
//   - pwm_i = (duty_i==8'hFF) | (pwm_cnt < duty_i).
//   - duty 0 gives always off; duty 0xFF gives always on.
//  Blink:
//   - 32-bit blink_cnt counts to PERIOD-1, then wraps and toggles phase (reset phase=1).
//   - PERIOD==0 holds phase=1.
//   - A write to PERIOD clears blink_cnt and sets phase=1.
//  led_o[i] = CTRL[0] & LED_ON[i] & pwm_i & (~(CTRL[1]&BLINK[i]) | phase).
//   - led_o is registered: 1 cycle after the inputs.
//  Reset mid-transaction: the channel is aborted and all state returns to reset values; the master must reissue.
// CONFIGURATION
//  LED_BLINK_EN defined: blink counter, phase, and BLINK/PERIOD registers present; CTRL[1] writable.
//  LED_BLINK_EN undefined:
//   - BLINK/PERIOD read 0 with RRESP=OKAY; writes to them are ignored with BRESP=OKAY.
//   - CTRL[1] reads 0; phase is constant 1.
// STRUCTURE
//  Package axi_led_pwm_pkg:
//   - register word-index localparams (CTRL..DUTY_BASE)
//   - RESP_OKAY/RESP_SLVERR constants
//   - ctrl_t packed struct {blink_en, enable}
//   - function apply_wstrb(old,new,strb)
//  Sub-module led_pwm_gen:
//   - owns pwm_cnt, prescaler, blink_cnt, phase
//   - computes registered led_o from register values
//  The top module holds the AXI FSMs and the register file.
// TESTING
//  1. Write LED_ON=0xFF, CTRL=1, DUTY_0..7=0x00..0x07; read back all -> values match, BRESP=RRESP=OKAY.
//  2. DUTY_3=0x40, PWM_DIV=1 -> led_o[3] high for exactly 64 of every 256 cycles; 0x00 -> never high; 0xFF -> always high.
//  3. Write WSTRB=4'b0001, data 0xAABBCCDD to PERIOD (old 0) -> readback 0x000000DD.
//  4. Read 0x3C (NUM_LEDS=8) -> RDATA=0, RRESP=2'b10; write there -> BRESP=2'b10, no register change.
//  5. LED_BLINK_EN set, PERIOD=10, CTRL=3, BLINK[0]=1, DUTY_0=0xFF -> led_o[0] toggles every 10 cycles.
//  6. Hold BREADY/RREADY low for 20 cycles; next AW/W/AR not accepted and BVALID/RVALID stay high.
//     Then assert ARESETN low mid-burst -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/axi_led_pwm_pkg.sv
// Shared definitions for the AXI4-Lite LED PWM controller: register word
// indices, response codes, the CTRL layout, FSM encodings and the
// byte-strobe merge helper.
package axi_led_pwm_pkg;

  localparam int unsigned REG_CTRL      = 0;
  localparam int unsigned REG_LED_ON    = 1;
  localparam int unsigned REG_BLINK     = 2;
  localparam int unsigned REG_PERIOD    = 3;
  localparam int unsigned REG_DUTY_BASE = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic blink_en;
    logic enable;
  } ctrl_t;

  typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} rd_state_t;

  // Merge new write data into the old register value, byte lane by byte lane.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_led_pwm_ctrl_led_pwm_gen.sv
// LED drive generator: free-running PWM counter with prescaler, blink
// half-period counter and phase, and the registered LED output.
// Optional blink hardware is built only when LED_BLINK_EN is defined;
// otherwise the blink phase is tied high.
module led_pwm_gen
  import axi_led_pwm_pkg::*;
#(
  parameter int NUM_LEDS = 8,
  parameter int PWM_DIV  = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  ctrl_t                    i_ctrl,
  input  logic [NUM_LEDS-1:0]      i_led_on,
  input  logic [NUM_LEDS-1:0]      i_blink,
  input  logic [NUM_LEDS-1:0][7:0] i_duty,
  input  logic [31:0]              i_period,
  input  logic                     i_period_wr,
  output logic [NUM_LEDS-1:0]      o_led
);

  localparam int DIVW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

  logic [DIVW-1:0]     r_pre;
  logic [7:0]          r_pwm_cnt;
  logic                w_phase;
  logic [NUM_LEDS-1:0] w_pwm;
  logic [NUM_LEDS-1:0] r_led;

  // Prescaler is a down-counter; the PWM counter steps on its terminal count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pre     <= '0;
      r_pwm_cnt <= '0;
    end else if (r_pre == '0) begin
      r_pre     <= DIVW'(PWM_DIV - 1);
      r_pwm_cnt <= r_pwm_cnt + 8'd1;
    end else begin
      r_pre <= r_pre - 1'b1;
    end
  end

`ifdef LED_BLINK_EN
  logic [31:0] r_blink_cnt;
  logic        r_phase;

  // Blink counter wraps at PERIOD-1 and flips the phase; a PERIOD write restarts it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
    end else if (i_period_wr || (i_period == 32'd0)) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
    end else if (r_blink_cnt >= i_period - 32'd1) begin
      r_blink_cnt <= '0;
      r_phase     <= ~r_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + 32'd1;
    end
  end

  assign w_phase = r_phase;
`else
  logic w_unused;
  assign w_unused = ^{i_period, i_period_wr};
  assign w_phase  = 1'b1;
`endif

  // Per-LED PWM compare; full-scale duty forces the LED on for the whole period.
  always_comb begin
    w_pwm = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      w_pwm[i] = (i_duty[i] == 8'hFF) | (r_pwm_cnt < i_duty[i]);
    end
  end

  // Registered LED drive combining enable, on mask, PWM and masked blink.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_led <= '0;
    end else begin
      r_led <= {NUM_LEDS{i_ctrl.enable}} & i_led_on & w_pwm &
               (~({NUM_LEDS{i_ctrl.blink_en}} & i_blink) | {NUM_LEDS{w_phase}});
    end
  end

  assign o_led = r_led;

endmodule

// File: rtl/axi_led_pwm_ctrl.sv
// AXI4-Lite slave with register file driving NUM_LEDS PWM/blink LEDs.
// Define LED_BLINK_EN to build the BLINK/PERIOD registers, CTRL[1] and the
// blink counter; without it those registers read 0 and ignore writes.
//
// Write FSM                          | Read FSM
//  state  | meaning                  |  state  | meaning
//  W_IDLE | waiting for AW+W valid   |  R_IDLE | waiting for AR valid
//  W_ACK  | AWREADY/WREADY high,     |  R_ACK  | ARREADY high, data
//         | register written at edge |         | captured at edge
//  W_RESP | BVALID held until BREADY |  R_DATA | RVALID held until RREADY
module axi_led_pwm_ctrl
  import axi_led_pwm_pkg::*;
#(
  parameter int NUM_LEDS           = 8,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int PWM_DIV            = 1
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [NUM_LEDS-1:0]             led_o
);

  if (C_S_AXI_DATA_WIDTH != 32) begin : g_err_dw
    $error("axi_led_pwm_ctrl: C_S_AXI_DATA_WIDTH must be 32");
  end
  if ((NUM_LEDS < 1) || (NUM_LEDS > 32)) begin : g_err_leds
    $error("axi_led_pwm_ctrl: NUM_LEDS must be 1..32");
  end
  if ((2 ** C_S_AXI_ADDR_WIDTH) < (16 + 4 * NUM_LEDS)) begin : g_err_aw
    $error("axi_led_pwm_ctrl: C_S_AXI_ADDR_WIDTH too small for the register map");
  end
  if (PWM_DIV < 1) begin : g_err_div
    $error("axi_led_pwm_ctrl: PWM_DIV must be >= 1");
  end

  localparam int unsigned NUM_WORDS = REG_DUTY_BASE + unsigned'(NUM_LEDS);

  wr_state_t                  r_wr_state;
  rd_state_t                  r_rd_state;
  logic                       r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
  logic [1:0]                 r_bresp, r_rresp;
  logic [31:0]                r_rdata;

  ctrl_t                      r_ctrl;
  logic [NUM_LEDS-1:0]        r_led_on;
  logic [NUM_LEDS-1:0][7:0]   r_duty;
  logic [NUM_LEDS-1:0]        w_blink;
  logic [31:0]                w_period;

  logic [31:0]                w_awidx, w_aridx;
  logic                       w_aw_mapped, w_ar_mapped;
  logic [31:0]                w_aw_old, w_ar_data, w_wr_word;
  logic                       w_wr_en, w_period_wr;
  logic                       w_unused;

`ifdef LED_BLINK_EN
  logic [NUM_LEDS-1:0]        r_blink;
  logic [31:0]                r_period;
  assign w_blink  = r_blink;
  assign w_period = r_period;
`else
  assign w_blink  = '0;
  assign w_period = '0;
`endif

  assign w_awidx     = 32'(S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2]);
  assign w_aridx     = 32'(S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]);
  assign w_aw_mapped = (w_awidx < NUM_WORDS);
  assign w_ar_mapped = (w_aridx < NUM_WORDS);
  assign w_unused    = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0],
                         S_AXI_ARADDR[1:0], w_wr_word};

  function automatic logic [31:0] reg_value(input logic [31:0] idx);
    logic [31:0] v;
    v = '0;
    if (idx == REG_CTRL) begin
      v[1:0] = {r_ctrl.blink_en, r_ctrl.enable};
    end else if (idx == REG_LED_ON) begin
      v[NUM_LEDS-1:0] = r_led_on;
    end else if (idx == REG_BLINK) begin
      v[NUM_LEDS-1:0] = w_blink;
    end else if (idx == REG_PERIOD) begin
      v = w_period;
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (idx == REG_DUTY_BASE + unsigned'(i)) v[7:0] = r_duty[i];
      end
    end
    return v;
  endfunction

  // Register read-back for both the write merge and the read channel; unmapped words give 0.
  always_comb begin
    w_aw_old  = reg_value(w_awidx);
    w_ar_data = reg_value(w_aridx);
  end

  assign w_wr_word   = apply_wstrb(w_aw_old, S_AXI_WDATA, S_AXI_WSTRB);
  assign w_wr_en     = (r_wr_state == W_ACK) && w_aw_mapped;
  assign w_period_wr = w_wr_en && (w_awidx == REG_PERIOD);

  // Write channel: accept AW and W together, then hold the response until BREADY.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_wr_state <= W_IDLE;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
    end else begin
      case (r_wr_state)
        W_IDLE: if (S_AXI_AWVALID && S_AXI_WVALID) begin
          r_awready  <= 1'b1;
          r_wready   <= 1'b1;
          r_wr_state <= W_ACK;
        end
        W_ACK: begin
          r_awready  <= 1'b0;
          r_wready   <= 1'b0;
          r_bvalid   <= 1'b1;
          r_bresp    <= w_aw_mapped ? RESP_OKAY : RESP_SLVERR;
          r_wr_state <= W_RESP;
        end
        W_RESP: if (S_AXI_BREADY) begin
          r_bvalid   <= 1'b0;
          r_wr_state <= W_IDLE;
        end
        default: r_wr_state <= W_IDLE;
      endcase
    end
  end

  // Read channel: one address at a time, data captured before any same-edge write lands.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_rd_state <= R_IDLE;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rresp    <= RESP_OKAY;
      r_rdata    <= '0;
    end else begin
      case (r_rd_state)
        R_IDLE: if (S_AXI_ARVALID) begin
          r_arready  <= 1'b1;
          r_rd_state <= R_ACK;
        end
        R_ACK: begin
          r_arready  <= 1'b0;
          r_rvalid   <= 1'b1;
          r_rdata    <= w_ar_data;
          r_rresp    <= w_ar_mapped ? RESP_OKAY : RESP_SLVERR;
          r_rd_state <= R_DATA;
        end
        R_DATA: if (S_AXI_RREADY) begin
          r_rvalid   <= 1'b0;
          r_rd_state <= R_IDLE;
        end
        default: r_rd_state <= R_IDLE;
      endcase
    end
  end

  // Register file update on the write handshake edge, honouring byte strobes.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_ctrl   <= '0;
      r_led_on <= '0;
      r_duty   <= '0;
`ifdef LED_BLINK_EN
      r_blink  <= '0;
      r_period <= '0;
`endif
    end else if (w_wr_en) begin
      if (w_awidx == REG_CTRL) begin
        r_ctrl.enable <= w_wr_word[0];
`ifdef LED_BLINK_EN
        r_ctrl.blink_en <= w_wr_word[1];
`else
        r_ctrl.blink_en <= 1'b0;
`endif
      end
      if (w_awidx == REG_LED_ON) r_led_on <= w_wr_word[NUM_LEDS-1:0];
`ifdef LED_BLINK_EN
      if (w_awidx == REG_BLINK)  r_blink  <= w_wr_word[NUM_LEDS-1:0];
      if (w_awidx == REG_PERIOD) r_period <= w_wr_word;
`endif
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (w_awidx == REG_DUTY_BASE + unsigned'(i)) r_duty[i] <= w_wr_word[7:0];
      end
    end
  end

  led_pwm_gen #(
    .NUM_LEDS (NUM_LEDS),
    .PWM_DIV  (PWM_DIV)
  ) u_led_pwm_gen (
    .i_clk       (ACLK),
    .i_rst_n     (ARESETN),
    .i_ctrl      (r_ctrl),
    .i_led_on    (r_led_on),
    .i_blink     (w_blink),
    .i_duty      (r_duty),
    .i_period    (w_period),
    .i_period_wr (w_period_wr),
    .o_led       (led_o)
  );

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RRESP   = r_rresp;
  assign S_AXI_RDATA   = r_rdata;

endmodule
